// File: rtl/nios_jtag_dbg_pkg.sv
// Shared types for the Nios II debug virtual-JTAG link: IR codes, host FSM states, state strobes.
// No logic of its own; latency and backpressure belong to the modules that import it.
package nios_jtag_dbg_pkg;

  localparam int SR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH         = 2;

  localparam logic [IR_WIDTH-1:0] IR_OCIMEM   = 2'd0;
  localparam logic [IR_WIDTH-1:0] IR_TRACEMEM = 2'd1;
  localparam logic [IR_WIDTH-1:0] IR_BREAK    = 2'd2;
  localparam logic [IR_WIDTH-1:0] IR_ENABLE   = 2'd3;

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} vji_state_e;

  typedef struct packed {
    logic uir;
    logic cdr;
    logic sdr;
    logic udr;
    logic rti;
  } vji_strb_t;

  // IDLE and DONE present run-test-idle to the target, like the RTI state itself.
  function automatic vji_strb_t state_strobes(input vji_state_e s);
    vji_strb_t st;
    st = '0;
    case (s)
      UIR:     st.uir = 1'b1;
      CDR:     st.cdr = 1'b1;
      SDR:     st.sdr = 1'b1;
      UDR:     st.udr = 1'b1;
      default: st.rti = 1'b1;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/nios_jtag_tck_gen.sv
// TCK generator: slots of TCK_DIV clk low then TCK_DIV clk high while run is set; tck parked low otherwise.
// Strobes are combinational from the counters and no backpressure exists; dropping run parks tck on the next edge.
module nios_jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic vji_tck,
  output logic slot_start,
  output logic tck_rise
);

  localparam int HC_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_DIV - 1);

  logic [HC_W-1:0] half_cnt;
  logic            half_end;

  // Both strobes flag the cycle whose closing edge raises tck or begins the next slot.
  assign half_end   = run && (half_cnt == HC_LAST);
  assign tck_rise   = half_end && !vji_tck;
  assign slot_start = half_end && vji_tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      vji_tck  <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      vji_tck  <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      vji_tck  <= ~vji_tck;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_jtag_vji_host.sv
// Virtual-JTAG initiator: one command becomes UIR/CDR/SDR/UDR/RTI slots; 1+2*TCK_DIV*(SR_WIDTH+3+RTI_SLOTS) clk accept-to-response.
// One command in flight; cmd_ready stays low until the response handshakes. NIOS_JTAG_VJI_HOST_SKIP_IR_EN omits UIR when the IR is unchanged.
module nios_jtag_vji_host
  import nios_jtag_dbg_pkg::*;
#(
  parameter int SR_WIDTH  = SR_WIDTH_DEFAULT,
  parameter int TCK_DIV   = 2,
  parameter int RTI_SLOTS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_uir,
  output logic                vji_rti
);

  localparam int SC_MAX = (SR_WIDTH > RTI_SLOTS) ? SR_WIDTH : RTI_SLOTS;
  localparam int SC_W   = $clog2(SC_MAX) + 1;
  localparam logic [SC_W-1:0] SDR_LAST = SC_W'(SR_WIDTH - 1);
  localparam logic [SC_W-1:0] RTI_LAST = SC_W'(RTI_SLOTS - 1);

  vji_state_e          state;
  vji_strb_t           strb;
  logic [SC_W-1:0]     slot_cnt;
  logic [SR_WIDTH-1:0] tx_dr;
  logic                run;
  logic                slot_start;
  logic                tck_rise;
  logic                cmd_acc;
  logic                skip_uir;

  assign run     = (state != IDLE) && (state != DONE);
  assign cmd_acc = cmd_valid && cmd_ready;
  assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = strb;

`ifdef NIOS_JTAG_VJI_HOST_SKIP_IR_EN
  logic done_once;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      done_once <= 1'b0;
    else if (state == DONE)
      done_once <= 1'b1;
  end

  assign skip_uir = done_once && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  nios_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .vji_tck    (vji_tck),
    .slot_start (slot_start),
    .tck_rise   (tck_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      strb       <= state_strobes(IDLE);
      slot_cnt   <= '0;
      tx_dr      <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      // Target samples on the same tck rise, so tdo and ir_out are taken on that edge.
      if (tck_rise) begin
        if (state == CDR) rsp_ir_out <= vji_ir_out;
        if (state == SDR) rsp_dr     <= {vji_tdo, rsp_dr[SR_WIDTH-1:1]};
      end
      case (state)
        IDLE: if (cmd_acc) begin
          cmd_ready <= 1'b0;
          tx_dr     <= cmd_dr;
          slot_cnt  <= '0;
          if (skip_uir) begin
            state <= CDR;
            strb  <= state_strobes(CDR);
          end else begin
            state     <= UIR;
            strb      <= state_strobes(UIR);
            vji_ir_in <= cmd_ir;
          end
        end
        UIR: if (slot_start) begin
          state    <= CDR;
          strb     <= state_strobes(CDR);
          slot_cnt <= '0;
        end
        CDR: if (slot_start) begin
          state    <= SDR;
          strb     <= state_strobes(SDR);
          slot_cnt <= '0;
          vji_tdi  <= tx_dr[0];
          tx_dr    <= tx_dr >> 1;
        end
        SDR: if (slot_start) begin
          if (slot_cnt == SDR_LAST) begin
            state    <= UDR;
            strb     <= state_strobes(UDR);
            slot_cnt <= '0;
            vji_tdi  <= 1'b0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
            vji_tdi  <= tx_dr[0];
            tx_dr    <= tx_dr >> 1;
          end
        end
        UDR: if (slot_start) begin
          state    <= RTI;
          strb     <= state_strobes(RTI);
          slot_cnt <= '0;
        end
        RTI: if (slot_start) begin
          if (slot_cnt == RTI_LAST) begin
            state    <= DONE;
            strb     <= state_strobes(DONE);
            slot_cnt <= '0;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
            strb      <= state_strobes(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          strb  <= state_strobes(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_jtag_vji_host.sv
// Bench for nios_jtag_vji_host: random commands against a shift-register target model and slot-count arithmetic.
// Covers latency, strobe one-hot, held cmd_valid, delayed rsp_ready, mid-sequence reset and a TCK_DIV=1 instance.
`timescale 1ns/1ps
module tb_nios_jtag_vji_host;

  localparam int W = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]   cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [W-1:0] cmd_dr, rsp_dr;
  logic         vji_tck, vji_tdi, vji_tdo;
  logic         vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti;

  logic         cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
  logic [1:0]   cmd_ir_b, rsp_ir_out_b, vji_ir_in_b, vji_ir_out_b;
  logic [W-1:0] cmd_dr_b, rsp_dr_b;
  logic         vji_tck_b, vji_tdi_b, vji_tdo_b;
  logic         vji_cdr_b, vji_sdr_b, vji_udr_b, vji_uir_b, vji_rti_b;

  assign vji_ir_out_b = 2'b01;

  nios_jtag_vji_host #(.SR_WIDTH(W), .TCK_DIV(2), .RTI_SLOTS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_uir(vji_uir), .vji_rti(vji_rti)
  );

  nios_jtag_vji_host #(.SR_WIDTH(W), .TCK_DIV(1), .RTI_SLOTS(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .rsp_ir_out(rsp_ir_out_b),
    .vji_tck(vji_tck_b), .vji_tdi(vji_tdi_b), .vji_tdo(vji_tdo_b),
    .vji_ir_in(vji_ir_in_b), .vji_ir_out(vji_ir_out_b),
    .vji_cdr(vji_cdr_b), .vji_sdr(vji_sdr_b), .vji_udr(vji_udr_b), .vji_uir(vji_uir_b), .vji_rti(vji_rti_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cumulative per-cycle counters; tasks take differences across a command.
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_tck_hi = 0, n_rsp_hi = 0;
  int n_onehot_bad = 0, n_onehot_bad_b = 0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_uir    += int'(vji_uir);
      n_cdr    += int'(vji_cdr);
      n_sdr    += int'(vji_sdr);
      n_udr    += int'(vji_udr);
      n_tck_hi += int'(vji_tck);
      n_rsp_hi += int'(rsp_valid);
      if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) != 1) n_onehot_bad++;
      if ($countones({vji_uir_b, vji_cdr_b, vji_sdr_b, vji_udr_b, vji_rti_b}) != 1) n_onehot_bad_b++;
    end
  end

  // Target DR: presents preload bit [k] on tdo before the k-th shift, records tdi bits LSB-first.
  int           n_shift = 0;
  int           shift_base = 0;
  int           tdo_idx;
  logic [W-1:0] tgt_pre = '0;
  logic [W-1:0] tdi_hist = '0;
  always @(posedge vji_tck) begin
    if (vji_sdr) begin
      n_shift  <= n_shift + 1;
      tdi_hist <= {vji_tdi, tdi_hist[W-1:1]};
    end
  end
  always_comb begin
    tdo_idx = n_shift - shift_base;
    vji_tdo = (tdo_idx >= 0 && tdo_idx < W) ? tgt_pre[tdo_idx[5:0]] : 1'b0;
  end

  logic [1:0] cur_ir = 2'd0;
  bit         completed = 1'b0;

  function automatic logic [W-1:0] rnd_dr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic run_cmd(input logic [1:0] ir, input logic [W-1:0] dr, input logic [W-1:0] pre,
                         input logic [1:0] iro, input int delay);
    int lat, ready_bad, hold_bad, exp_slots;
    int b_uir, b_cdr, b_sdr, b_udr, b_tck, b_oh;
    bit skip;
    logic [W-1:0] held;
    skip = 1'b0;
`ifdef NIOS_JTAG_VJI_HOST_SKIP_IR_EN
    skip = completed && (ir == cur_ir);
`endif
    exp_slots  = W + (skip ? 2 : 3) + 2;
    tgt_pre    = pre;
    shift_base = n_shift;
    vji_ir_out = iro;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr;
    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    check("accept_ready", cmd_ready, 1);
    if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; return; end
    @(posedge clk);
    b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr; b_tck = n_tck_hi; b_oh = n_onehot_bad;
    #1;
    check("ir_in_after_accept", vji_ir_in, ir);
    cmd_ir = ~ir; cmd_dr = rnd_dr();
    lat = 0; ready_bad = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (cmd_ready) ready_bad++;
      if (!rsp_valid) rsp_ready = 1'($urandom_range(0, 1));
    end while (!rsp_valid && lat < 400);
    rsp_ready = 1'b0;
    check("latency", lat, 1 + 4 * exp_slots);
    check("no_second_accept", ready_bad, 0);
    check("rsp_dr", rsp_dr, pre);
    check("rsp_ir_out", rsp_ir_out, iro);
    check("target_dr", tdi_hist, dr);
    check("ir_in_hold", vji_ir_in, ir);
    check("uir_cycles", n_uir - b_uir, skip ? 0 : 4);
    check("cdr_cycles", n_cdr - b_cdr, 4);
    check("sdr_cycles", n_sdr - b_sdr, 4 * W);
    check("udr_cycles", n_udr - b_udr, 4);
    check("tck_high_cycles", n_tck_hi - b_tck, 2 * exp_slots);
    check("strobe_onehot", n_onehot_bad - b_oh, 0);
    held = rsp_dr; hold_bad = 0;
    repeat (delay) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_dr !== held || cmd_ready) hold_bad++;
    end
    check("rsp_hold", hold_bad, 0);
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("ready_return", cmd_ready, 1);
    completed = 1'b1;
    cur_ir    = ir;
  endtask

  task automatic run_b(input logic tdo_val);
    int lat, rises, hi;
    logic prev;
    vji_tdo_b = tdo_val;
    @(negedge clk);
    cmd_valid_b = 1'b1; cmd_ir_b = 2'($urandom_range(0, 3)); cmd_dr_b = rnd_dr();
    lat = 0;
    while (cmd_ready_b !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    check("b_accept_ready", cmd_ready_b, 1);
    @(posedge clk); #1;
    cmd_valid_b = 1'b0;
    lat = 0; rises = 0; hi = 0; prev = 1'b0;
    do begin
      @(posedge clk); #1; lat++;
      if (vji_tck_b) hi++;
      if (vji_tck_b && !prev) rises++;
      prev = vji_tck_b;
    end while (!rsp_valid_b && lat < 400);
    check("b_latency", lat, 1 + 2 * 1 * (W + 3 + 1));
    check("b_tck_rises", rises, W + 3 + 1);
    check("b_tck_high", hi, W + 3 + 1);
    check("b_rsp_dr", rsp_dr_b, {W{tdo_val}});
    check("b_rsp_ir_out", rsp_ir_out_b, 2'b01);
    @(negedge clk); rsp_ready_b = 1'b1;
    @(posedge clk); #1; rsp_ready_b = 1'b0;
    check("b_ready_return", cmd_ready_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] r_ir, r_iro;
    int r_dly, base;
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0; vji_ir_out = '0;
    cmd_valid_b = 1'b0; cmd_ir_b = '0; cmd_dr_b = '0; rsp_ready_b = 1'b0; vji_tdo_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", vji_tck, 0);
    check("rst_tdi", vji_tdi, 0);
    check("rst_ir_in", vji_ir_in, 0);
    check("rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 5'b00001);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dr", rsp_dr, 0);
    check("rst_rsp_ir_out", rsp_ir_out, 0);
    @(negedge clk); reset_n = 1'b1;

    run_cmd(2'd2, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 2'b11, 10);
    run_cmd(2'd1, rnd_dr(), rnd_dr(), 2'b10, 3);
    run_cmd(2'd1, rnd_dr(), rnd_dr(), 2'b01, 0);
    for (int i = 0; i < 6; i++) begin
      r_ir  = 2'($urandom_range(0, 3));
      r_iro = 2'($urandom_range(0, 3));
      r_dly = $urandom_range(0, 5);
      run_cmd(r_ir, rnd_dr(), rnd_dr(), r_iro, r_dly);
    end

    // Reset in the middle of SDR.
    tgt_pre = rnd_dr(); shift_base = n_shift;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 2'd3; cmd_dr = rnd_dr();
    base = 0;
    while (cmd_ready !== 1'b1 && base < 50) begin @(negedge clk); base++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_tck", vji_tck, 0);
    check("midrst_sdr", vji_sdr, 0);
    check("midrst_rti", vji_rti, 1);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_ir_in", vji_ir_in, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = n_rsp_hi;
    repeat (200) @(posedge clk);
    #1;
    check("midrst_no_rsp", n_rsp_hi - base, 0);
    completed = 1'b0;
    cur_ir    = 2'd0;

    run_cmd(2'd0, rnd_dr(), rnd_dr(), 2'b00, 2);
    run_cmd(2'd0, rnd_dr(), rnd_dr(), 2'b11, 1);

    run_b(1'b1);
    run_b(1'b0);
    check("b_strobe_onehot", n_onehot_bad_b, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
